chip_digital_eval_ctrl: RTL and testbench

// - Board-side sequencer that exercises the chip digital section (deconv kernel estimator).
// - On kernel_start it resets the chip, serially loads the transfer-function coefficients,

---
 rtl/chip_digital_eval_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_chip_digital_eval_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chip_digital_eval_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : chip_digital_eval_ctrl
// Description : Board-side sequencer for the chip digital section (deconv
//               kernel estimator). On kernel_start it holds the chip in
//               reset, serially loads the transfer-function coefficients,
//               runs the frequency evaluation, then dumps the ADC, phase and
//               TF-coeff SRAMs in debug mode. The chip's single serial
//               stream is demultiplexed into registered per-stream pairs.
// Ports       : clk, sys_rst (async, active high)
//               kernel_start, bypass_adc_eval, freq_eval_done  - control in
//               serial_out, serial_out_valid                   - chip stream
//               rst_n, load_en, debug_en, serial_in, sram_select,
//               adc_start, adc_bypass_en                       - chip control
//               chip_eval_done                                 - sequence done
//               chip_*_serial_data / _valid                    - routed pairs
// Revision    : 1.0 - initial release
// ============================================================================
module chip_digital_eval_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_COEFF   = 5,
  parameter logic [NUM_COEFF*DATA_WIDTH-1:0] COEFF_INIT = 80'h2000_0000_2000_0000_0000,
  parameter int RST_CYCLES  = 4,
  parameter int ADC_PERIOD  = 16,
  parameter int DUMP_CYCLES = 32768
) (
  input  logic       clk,
  input  logic       sys_rst,
  input  logic       kernel_start,
  input  logic       bypass_adc_eval,
  input  logic       freq_eval_done,
  input  logic       serial_out,
  input  logic       serial_out_valid,
  output logic       rst_n,
  output logic       load_en,
  output logic       debug_en,
  output logic       serial_in,
  output logic [1:0] sram_select,
  output logic       adc_start,
  output logic       adc_bypass_en,
  output logic       chip_eval_done,
  output logic       chip_adc_serial_data,
  output logic       chip_adc_serial_data_valid,
  output logic       chip_mag_serial_data,
  output logic       chip_mag_serial_data_valid,
  output logic       chip_phase_serial_data,
  output logic       chip_phase_serial_data_valid,
  output logic       chip_phase_sram_serial_data,
  output logic       chip_phase_sram_serial_data_valid,
  output logic       chip_tf_coeff_sram_serial_data,
  output logic       chip_tf_coeff_sram_serial_data_valid
);

  localparam int          LOAD_LEN  = NUM_COEFF * DATA_WIDTH;
  localparam logic [31:0] RST_LAST  = 32'(RST_CYCLES - 1);
  localparam logic [31:0] LOAD_LAST = 32'(LOAD_LEN - 1);
  localparam logic [31:0] DUMP_LAST = 32'(DUMP_CYCLES - 1);
  localparam logic [31:0] ADC_LAST  = 32'(ADC_PERIOD - 1);
  localparam logic [31:0] BIT_LAST  = 32'(DATA_WIDTH - 1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CRST     = 3'd1;
  localparam logic [2:0] ST_LOAD     = 3'd2;
  localparam logic [2:0] ST_RUN      = 3'd3;
  localparam logic [2:0] ST_DUMP_ADC = 3'd4;
  localparam logic [2:0] ST_DUMP_PH  = 3'd5;
  localparam logic [2:0] ST_DUMP_TF  = 3'd6;
  localparam logic [2:0] ST_DONE     = 3'd7;

  logic [2:0]          state_q, state_d;
  logic [31:0]         cnt_q, cnt_d;          // phase cycle counter
  logic [31:0]         adc_cnt_q, adc_cnt_d;  // adc_start period counter
  logic [31:0]         bit_cnt_q, bit_cnt_d;  // valid bits within current word
  logic                word_odd_q, word_odd_d;
  logic                bypass_q, bypass_d;
  logic [LOAD_LEN-1:0] sr_q, sr_d;            // coefficient shift register
  logic [4:0]          vld_q, vld_d;          // {adc, mag, phase, phase_sram, tf}
  logic [4:0]          dat_q, dat_d;
  logic [4:0]          route_sel;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 32'd1;
    adc_cnt_d  = 32'd0;
    bit_cnt_d  = 32'd0;
    word_odd_d = 1'b0;
    bypass_d   = bypass_q;
    sr_d       = sr_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        cnt_d = 32'd0;
        if (kernel_start) begin
          state_d  = ST_CRST;
          bypass_d = bypass_adc_eval;
        end
      end
      ST_CRST: begin
        // Preload so the first LOAD cycle already presents the MSB.
        sr_d = COEFF_INIT;
        if (cnt_q == RST_LAST) begin
          state_d = ST_LOAD;
          cnt_d   = 32'd0;
        end
      end
      ST_LOAD: begin
        sr_d = sr_q << 1;
        if (cnt_q == LOAD_LAST) begin
          state_d = ST_RUN;
          cnt_d   = 32'd0;
        end
      end
      ST_RUN: begin
        cnt_d      = 32'd0;
        adc_cnt_d  = (adc_cnt_q == ADC_LAST) ? 32'd0 : adc_cnt_q + 32'd1;
        bit_cnt_d  = bit_cnt_q;
        word_odd_d = word_odd_q;
        if (serial_out_valid) begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d  = 32'd0;
            word_odd_d = ~word_odd_q;
          end else begin
            bit_cnt_d = bit_cnt_q + 32'd1;
          end
        end
        if (freq_eval_done) begin
          state_d = bypass_q ? ST_DUMP_PH : ST_DUMP_ADC;
        end
      end
      ST_DUMP_ADC: begin
        if (cnt_q == DUMP_LAST) begin
          state_d = ST_DUMP_PH;
          cnt_d   = 32'd0;
        end
      end
      ST_DUMP_PH: begin
        if (cnt_q == DUMP_LAST) begin
          state_d = ST_DUMP_TF;
          cnt_d   = 32'd0;
        end
      end
      ST_DUMP_TF: begin
        if (cnt_q == DUMP_LAST) begin
          state_d = ST_DONE;
          cnt_d   = 32'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 32'd0;
      end
    endcase
  end

  // Stream selection from the current state; words alternate mag/phase in RUN.
  always_comb begin
    route_sel    = 5'b00000;
    route_sel[4] = (state_q == ST_DUMP_ADC);
    route_sel[3] = (state_q == ST_RUN) && !word_odd_q;
    route_sel[2] = (state_q == ST_RUN) &&  word_odd_q;
    route_sel[1] = (state_q == ST_DUMP_PH);
    route_sel[0] = (state_q == ST_DUMP_TF);
    vld_d        = route_sel & {5{serial_out_valid}};
    dat_d        = vld_d & {5{serial_out}};
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 32'd0;
      adc_cnt_q  <= 32'd0;
      bit_cnt_q  <= 32'd0;
      word_odd_q <= 1'b0;
      bypass_q   <= 1'b0;
      sr_q       <= '0;
      vld_q      <= 5'b00000;
      dat_q      <= 5'b00000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      adc_cnt_q  <= adc_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      word_odd_q <= word_odd_d;
      bypass_q   <= bypass_d;
      sr_q       <= sr_d;
      vld_q      <= vld_d;
      dat_q      <= dat_d;
    end
  end

  // Control outputs decode straight from the state so an async reset
  // drops them (and rst_n) without waiting for a clock.
  always_comb begin
    sram_select = 2'b00;
    case (state_q)
      ST_LOAD:    sram_select = 2'b11;
      ST_RUN:     sram_select = 2'b01;
      ST_DUMP_PH: sram_select = 2'b10;
      ST_DUMP_TF: sram_select = 2'b11;
      default:    sram_select = 2'b00;
    endcase
  end

  assign rst_n          = (state_q != ST_IDLE) && (state_q != ST_CRST);
  assign load_en        = (state_q == ST_LOAD);
  assign debug_en       = (state_q == ST_DUMP_ADC) || (state_q == ST_DUMP_PH) ||
                          (state_q == ST_DUMP_TF);
  assign serial_in      = (state_q == ST_LOAD) && sr_q[LOAD_LEN-1];
  assign adc_start      = (state_q == ST_RUN) && (adc_cnt_q == 32'd0) && !freq_eval_done;
  assign adc_bypass_en  = bypass_q;
  assign chip_eval_done = (state_q == ST_DONE);

  assign chip_adc_serial_data                 = dat_q[4];
  assign chip_adc_serial_data_valid           = vld_q[4];
  assign chip_mag_serial_data                 = dat_q[3];
  assign chip_mag_serial_data_valid           = vld_q[3];
  assign chip_phase_serial_data               = dat_q[2];
  assign chip_phase_serial_data_valid         = vld_q[2];
  assign chip_phase_sram_serial_data          = dat_q[1];
  assign chip_phase_sram_serial_data_valid    = vld_q[1];
  assign chip_tf_coeff_sram_serial_data       = dat_q[0];
  assign chip_tf_coeff_sram_serial_data_valid = vld_q[0];

endmodule
`default_nettype wire

// File: tb/tb_chip_digital_eval_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_chip_digital_eval_ctrl
// Description : Self-checking bench for chip_digital_eval_ctrl. Random serial
//               traffic and ignored-control noise are checked against a
//               phase-by-phase model of the sequence and of stream routing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chip_digital_eval_ctrl;

  localparam int          DW    = 16;
  localparam int          NC    = 5;
  localparam int          NBITS = DW * NC;
  localparam logic [79:0] COEFF = 80'hA5C3_1F0E_9B27_64D8_3C5A;
  localparam int          RSTC  = 4;
  localparam int          ADCP  = 16;
  localparam int          DUMPC = 64;

  localparam int S_NONE = -1;
  localparam int S_ADC  = 0;
  localparam int S_MAG  = 1;
  localparam int S_PH   = 2;
  localparam int S_PHS  = 3;
  localparam int S_TF   = 4;

  logic       clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       kernel_start = 1'b0;
  logic       bypass_adc_eval = 1'b0;
  logic       freq_eval_done = 1'b0;
  logic       serial_out = 1'b0;
  logic       serial_out_valid = 1'b0;
  logic       rst_n, load_en, debug_en, serial_in, adc_start, adc_bypass_en, chip_eval_done;
  logic [1:0] sram_select;
  logic       adc_d, adc_v, mag_d, mag_v, ph_d, ph_v, phs_d, phs_v, tf_d, tf_v;
  logic [9:0] pairs;

  logic [79:0] coeff_v;
  logic [9:0]  pend;     // expected routed pairs for the next sample
  int          n_cmp = 0;
  int          n_err = 0;

  assign pairs = {adc_d, adc_v, mag_d, mag_v, ph_d, ph_v, phs_d, phs_v, tf_d, tf_v};

  always #5 clk = ~clk;

  chip_digital_eval_ctrl #(
    .DATA_WIDTH(DW), .NUM_COEFF(NC), .COEFF_INIT(COEFF),
    .RST_CYCLES(RSTC), .ADC_PERIOD(ADCP), .DUMP_CYCLES(DUMPC)
  ) dut (
    .clk(clk), .sys_rst(sys_rst), .kernel_start(kernel_start),
    .bypass_adc_eval(bypass_adc_eval), .freq_eval_done(freq_eval_done),
    .serial_out(serial_out), .serial_out_valid(serial_out_valid),
    .rst_n(rst_n), .load_en(load_en), .debug_en(debug_en), .serial_in(serial_in),
    .sram_select(sram_select), .adc_start(adc_start), .adc_bypass_en(adc_bypass_en),
    .chip_eval_done(chip_eval_done),
    .chip_adc_serial_data(adc_d), .chip_adc_serial_data_valid(adc_v),
    .chip_mag_serial_data(mag_d), .chip_mag_serial_data_valid(mag_v),
    .chip_phase_serial_data(ph_d), .chip_phase_serial_data_valid(ph_v),
    .chip_phase_sram_serial_data(phs_d), .chip_phase_sram_serial_data_valid(phs_v),
    .chip_tf_coeff_sram_serial_data(tf_d), .chip_tf_coeff_sram_serial_data_valid(tf_v)
  );

  // Expected registered pair vector: the selected stream carries {data&valid, valid}.
  function automatic logic [9:0] route(int s, logic d, logic v);
    logic [9:0] r;
    r = '0;
    if (s != S_NONE && v) begin
      r[(4 - s) * 2 + 1] = d;
      r[(4 - s) * 2]     = 1'b1;
    end
    return r;
  endfunction

  task automatic rand_serial();
    serial_out       = 1'($urandom);
    serial_out_valid = 1'($urandom);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (rst_n !== 1'b0) begin n_err++; $display("FAIL reset_rst_n got=%b exp=0", rst_n); end
    n_cmp++; if (load_en !== 1'b0) begin n_err++; $display("FAIL reset_load_en got=%b exp=0", load_en); end
    n_cmp++; if (debug_en !== 1'b0) begin n_err++; $display("FAIL reset_debug_en got=%b exp=0", debug_en); end
    n_cmp++; if (serial_in !== 1'b0) begin n_err++; $display("FAIL reset_serial_in got=%b exp=0", serial_in); end
    n_cmp++; if (sram_select !== 2'b00) begin n_err++; $display("FAIL reset_sram_select got=%b exp=00", sram_select); end
    n_cmp++; if (adc_start !== 1'b0) begin n_err++; $display("FAIL reset_adc_start got=%b exp=0", adc_start); end
    n_cmp++; if (adc_bypass_en !== 1'b0) begin n_err++; $display("FAIL reset_adc_bypass_en got=%b exp=0", adc_bypass_en); end
    n_cmp++; if (chip_eval_done !== 1'b0) begin n_err++; $display("FAIL reset_chip_eval_done got=%b exp=0", chip_eval_done); end
    n_cmp++; if (pairs !== 10'b0) begin n_err++; $display("FAIL reset_pairs got=%b exp=%b", pairs, 10'b0); end
    sys_rst = 1'b0;
    pend    = '0;
    for (int i = 0; i < 3; i++) begin
      rand_serial();
      #1;
      n_cmp++; if (rst_n !== 1'b0) begin n_err++; $display("FAIL idle_rst_n cyc=%0d got=%b exp=0", i, rst_n); end
      n_cmp++; if (pairs !== pend) begin n_err++; $display("FAIL idle_pairs cyc=%0d got=%b exp=%b", i, pairs, pend); end
      pend = '0;
      @(posedge clk); #1;
    end
  endtask

  // Start request, CRST hold and (the first nload cycles of) the coefficient load.
  task automatic test_start_load(logic byp, int nload, logic from_done);
    kernel_start    = 1'b1;
    bypass_adc_eval = byp;
    rand_serial();
    #1;
    n_cmp++; if (chip_eval_done !== from_done) begin n_err++; $display("FAIL start_done_flag got=%b exp=%b", chip_eval_done, from_done); end
    n_cmp++; if (pairs !== pend) begin n_err++; $display("FAIL start_pairs got=%b exp=%b", pairs, pend); end
    pend = '0;
    @(posedge clk); #1;
    for (int i = 0; i < RSTC; i++) begin
      kernel_start = 1'($urandom); bypass_adc_eval = 1'($urandom); rand_serial();
      #1;
      n_cmp++; if (rst_n !== 1'b0) begin n_err++; $display("FAIL crst_rst_n cyc=%0d got=%b exp=0", i, rst_n); end
      n_cmp++; if (load_en !== 1'b0) begin n_err++; $display("FAIL crst_load_en cyc=%0d got=%b exp=0", i, load_en); end
      n_cmp++; if (chip_eval_done !== 1'b0) begin n_err++; $display("FAIL crst_done cyc=%0d got=%b exp=0", i, chip_eval_done); end
      n_cmp++; if (pairs !== pend) begin n_err++; $display("FAIL crst_pairs cyc=%0d got=%b exp=%b", i, pairs, pend); end
      pend = '0;
      @(posedge clk); #1;
    end
    for (int i = 0; i < nload; i++) begin
      kernel_start = 1'($urandom); bypass_adc_eval = 1'($urandom); rand_serial();
      #1;
      n_cmp++; if (rst_n !== 1'b1) begin n_err++; $display("FAIL load_rst_n cyc=%0d got=%b exp=1", i, rst_n); end
      n_cmp++; if (load_en !== 1'b1) begin n_err++; $display("FAIL load_en cyc=%0d got=%b exp=1", i, load_en); end
      n_cmp++; if (sram_select !== 2'b11) begin n_err++; $display("FAIL load_sram_select cyc=%0d got=%b exp=11", i, sram_select); end
      n_cmp++; if (serial_in !== coeff_v[NBITS - 1 - i]) begin n_err++; $display("FAIL load_serial_in bit=%0d got=%b exp=%b", i, serial_in, coeff_v[NBITS - 1 - i]); end
      n_cmp++; if (debug_en !== 1'b0) begin n_err++; $display("FAIL load_debug_en cyc=%0d got=%b exp=0", i, debug_en); end
      n_cmp++; if (pairs !== pend) begin n_err++; $display("FAIL load_pairs cyc=%0d got=%b exp=%b", i, pairs, pend); end
      pend = '0;
      @(posedge clk); #1;
    end
    kernel_start = 1'b0;
  endtask

  // RUN for run_len cycles, then freq_eval_done on cycle run_len.
  task automatic test_run(logic byp, int run_len, int force_valid);
    int  vcount;
    logic exp_adc;
    vcount = 0;
    for (int i = 0; i <= run_len; i++) begin
      kernel_start     = 1'($urandom);
      bypass_adc_eval  = 1'($urandom);
      freq_eval_done   = (i == run_len);
      serial_out       = 1'($urandom);
      serial_out_valid = (i < force_valid) ? 1'b1 : 1'($urandom);
      exp_adc = ((i % ADCP) == 0) && (i != run_len);
      #1;
      n_cmp++; if (adc_start !== exp_adc) begin n_err++; $display("FAIL run_adc_start cyc=%0d got=%b exp=%b", i, adc_start, exp_adc); end
      n_cmp++; if (sram_select !== 2'b01) begin n_err++; $display("FAIL run_sram_select cyc=%0d got=%b exp=01", i, sram_select); end
      n_cmp++; if (debug_en !== 1'b0) begin n_err++; $display("FAIL run_debug_en cyc=%0d got=%b exp=0", i, debug_en); end
      n_cmp++; if (load_en !== 1'b0) begin n_err++; $display("FAIL run_load_en cyc=%0d got=%b exp=0", i, load_en); end
      n_cmp++; if (adc_bypass_en !== byp) begin n_err++; $display("FAIL run_bypass cyc=%0d got=%b exp=%b", i, adc_bypass_en, byp); end
      n_cmp++; if (pairs !== pend) begin n_err++; $display("FAIL run_pairs cyc=%0d got=%b exp=%b", i, pairs, pend); end
      pend = route(((vcount / DW) % 2 == 0) ? S_MAG : S_PH, serial_out, serial_out_valid);
      if (serial_out_valid) vcount++;
      @(posedge clk); #1;
    end
    freq_eval_done = 1'b0;
  endtask

  task automatic test_dump(int stream, logic [1:0] sel);
    for (int i = 0; i < DUMPC; i++) begin
      kernel_start   = 1'($urandom);
      freq_eval_done = 1'($urandom);
      rand_serial();
      #1;
      n_cmp++; if (debug_en !== 1'b1) begin n_err++; $display("FAIL dump_debug_en sel=%b cyc=%0d got=%b exp=1", sel, i, debug_en); end
      n_cmp++; if (sram_select !== sel) begin n_err++; $display("FAIL dump_sram_select cyc=%0d got=%b exp=%b", i, sram_select, sel); end
      n_cmp++; if (rst_n !== 1'b1) begin n_err++; $display("FAIL dump_rst_n sel=%b cyc=%0d got=%b exp=1", sel, i, rst_n); end
      n_cmp++; if (adc_start !== 1'b0) begin n_err++; $display("FAIL dump_adc_start sel=%b cyc=%0d got=%b exp=0", sel, i, adc_start); end
      n_cmp++; if (chip_eval_done !== 1'b0) begin n_err++; $display("FAIL dump_done sel=%b cyc=%0d got=%b exp=0", sel, i, chip_eval_done); end
      n_cmp++; if (pairs !== pend) begin n_err++; $display("FAIL dump_pairs sel=%b cyc=%0d got=%b exp=%b", sel, i, pairs, pend); end
      pend = route(stream, serial_out, serial_out_valid);
      @(posedge clk); #1;
    end
    kernel_start   = 1'b0;
    freq_eval_done = 1'b0;
  endtask

  task automatic test_done(int n);
    kernel_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      bypass_adc_eval = 1'($urandom);
      rand_serial();
      #1;
      n_cmp++; if (chip_eval_done !== 1'b1) begin n_err++; $display("FAIL done_flag cyc=%0d got=%b exp=1", i, chip_eval_done); end
      n_cmp++; if (debug_en !== 1'b0) begin n_err++; $display("FAIL done_debug_en cyc=%0d got=%b exp=0", i, debug_en); end
      n_cmp++; if (rst_n !== 1'b1) begin n_err++; $display("FAIL done_rst_n cyc=%0d got=%b exp=1", i, rst_n); end
      n_cmp++; if (load_en !== 1'b0) begin n_err++; $display("FAIL done_load_en cyc=%0d got=%b exp=0", i, load_en); end
      n_cmp++; if (pairs !== pend) begin n_err++; $display("FAIL done_pairs cyc=%0d got=%b exp=%b", i, pairs, pend); end
      pend = S_NONE == S_NONE ? route(S_NONE, serial_out, serial_out_valid) : '0;
      @(posedge clk); #1;
    end
  endtask

  // sys_rst asserted mid-cycle during LOAD, then a clean full restart.
  task automatic test_async_reset();
    test_start_load(1'b0, 20, 1'b1);
    serial_out_valid = 1'b1;
    #2;
    sys_rst = 1'b1;
    #1;
    n_cmp++; if (rst_n !== 1'b0) begin n_err++; $display("FAIL arst_rst_n got=%b exp=0", rst_n); end
    n_cmp++; if (load_en !== 1'b0) begin n_err++; $display("FAIL arst_load_en got=%b exp=0", load_en); end
    n_cmp++; if (sram_select !== 2'b00) begin n_err++; $display("FAIL arst_sram_select got=%b exp=00", sram_select); end
    n_cmp++; if (serial_in !== 1'b0) begin n_err++; $display("FAIL arst_serial_in got=%b exp=0", serial_in); end
    n_cmp++; if (adc_bypass_en !== 1'b0) begin n_err++; $display("FAIL arst_bypass got=%b exp=0", adc_bypass_en); end
    n_cmp++; if (pairs !== 10'b0) begin n_err++; $display("FAIL arst_pairs got=%b exp=%b", pairs, 10'b0); end
    @(posedge clk); #1;
    sys_rst = 1'b0;
    pend    = '0;
    test_start_load(1'b0, NBITS, 1'b0);
    test_run(1'b0, 20, 0);
    test_dump(S_ADC, 2'b00);
    test_dump(S_PHS, 2'b10);
    test_dump(S_TF, 2'b11);
    test_done(3);
  endtask

  initial begin
    coeff_v = COEFF;
    pend    = '0;
    test_reset();
    test_start_load(1'b0, NBITS, 1'b0);
    test_run(1'b0, 112, 40);
    test_dump(S_ADC, 2'b00);
    test_dump(S_PHS, 2'b10);
    test_dump(S_TF, 2'b11);
    test_done(10);
    test_start_load(1'b1, NBITS, 1'b1);
    test_run(1'b1, 37, 20);
    test_dump(S_PHS, 2'b10);
    test_dump(S_TF, 2'b11);
    test_done(5);
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
